// File: rtl/muldiv_unit.sv
// =============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MIPS multiply/divide unit with HI/LO registers.
//            Optional macro MULDIV_EARLY_OUT_EN shortens multiply and div-by-0.
// Revision : 1.0
// =============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } stateT;

   stateT              r_state;
   stateT              w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_aRaw;
   logic               r_isDiv;
   logic               r_negLo;
   logic               r_negHi;
   logic               r_bZero;

   logic               w_accept;
   logic               w_aNeg;
   logic               w_bNeg;
   logic [WIDTH-1:0]   w_aMag;
   logic [WIDTH-1:0]   w_bMag;
   logic [2*WIDTH-1:0] w_mulSum;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH:0]     w_divShift;
   logic [WIDTH:0]     w_divTrial;
   logic               w_divOk;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_lastIter;

   assign w_accept = start & ~flush;
   assign w_aNeg   = ~op[0] & operand_a[WIDTH-1];
   assign w_bNeg   = ~op[0] & operand_b[WIDTH-1];
   assign w_aMag   = w_aNeg ? -operand_a : operand_a;
   assign w_bMag   = w_bNeg ? -operand_b : operand_b;

   // Multiply: accumulator grows by a left-shifting multiplicand per set multiplier bit.
   assign w_mulSum = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_prod   = r_negLo ? -r_acc : r_acc;

   // Divide: remainder lives in r_acc's upper half, dividend/quotient in the lower half.
   assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_divTrial = w_divShift - {1'b0, r_mplier};
   assign w_divOk    = ~w_divTrial[WIDTH];
   assign w_quo      = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem      = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
   assign w_lastIter = (r_cnt == CNT_W'(1)) ||
                       (!r_isDiv && (r_mplier[WIDTH-1:1] == '0));
`else
   assign w_lastIter = (r_cnt == CNT_W'(1));
`endif

   assign busy = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
`ifdef MULDIV_EARLY_OUT_EN
               w_nextState = (op[1] && (operand_b == '0)) ? FINISH : RUN;
`else
               w_nextState = RUN;
`endif
            end
         end
         RUN: begin
            if (flush)           w_nextState = IDLE;
            else if (w_lastIter) w_nextState = FINISH;
         end
         FINISH:  w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_aRaw   <= '0;
         r_isDiv  <= 1'b0;
         r_negLo  <= 1'b0;
         r_negHi  <= 1'b0;
         r_bZero  <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (wr_hi) hi <= wr_data;
               if (wr_lo) lo <= wr_data;
               if (w_accept) begin
                  r_cnt    <= CNT_W'(WIDTH);
                  r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_aMag} : '0;
                  r_mcand  <= {{WIDTH{1'b0}}, w_aMag};
                  r_mplier <= w_bMag;
                  r_aRaw   <= operand_a;
                  r_isDiv  <= op[1];
                  r_negLo  <= w_aNeg ^ w_bNeg;
                  r_negHi  <= w_aNeg;
                  r_bZero  <= op[1] && (operand_b == '0);
               end
            end
            RUN: begin
               if (!flush) begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_isDiv) begin
                     r_acc <= {(w_divOk ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0]),
                               r_acc[WIDTH-2:0], w_divOk};
                  end else begin
                     r_acc    <= w_mulSum;
                     r_mcand  <= r_mcand << 1;
                     r_mplier <= r_mplier >> 1;
                  end
               end
            end
            FINISH: begin
               done     <= 1'b1;
               div_zero <= r_bZero;
               if (!r_isDiv) begin
                  hi <= w_prod[2*WIDTH-1:WIDTH];
                  lo <= w_prod[WIDTH-1:0];
               end else if (r_bZero) begin
                  hi <= r_aRaw;
                  lo <= '1;
               end else begin
                  hi <= w_rem;
                  lo <= w_quo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// =============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit (WIDTH=32).
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic        flush;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        wrHi;
   logic        wrLo;
   logic [31:0] wrData;
   logic        busy;
   logic        done;
   logic        divZero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .flush     (flush),
      .operand_a (operandA),
      .operand_b (operandB),
      .wr_hi     (wrHi),
      .wr_lo     (wrLo),
      .wr_data   (wrData),
      .busy      (busy),
      .done      (done),
      .div_zero  (divZero),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Latency from the start edge to the edge that writes hi/lo.
   function automatic int expLat(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] mag;
      int          bitLen;
      if (o[1]) return (b == 32'd0) ? 1 : 33;
      mag    = (!o[0] && b[31]) ? -b : b;
      bitLen = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) bitLen = i + 1;
      return ((bitLen < 1) ? 1 : bitLen) + 1;
`else
      return 33;
`endif
   endfunction

   // Called #1 after a rising edge; returns #1 after the edge following done.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi,
                        input logic [31:0] expLo, input logic expDz);
      int cyc;
      start = 1'b1; op = o; operandA = a; operandB = b;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".busy"}, {63'd0, busy}, 64'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".lat"}, 64'(cyc), 64'(expLat(o, b)));
      check({tag, ".hi"}, {32'd0, hi}, {32'd0, expHi});
      check({tag, ".lo"}, {32'd0, lo}, {32'd0, expLo});
      check({tag, ".dz"}, {63'd0, divZero}, {63'd0, expDz});
      check({tag, ".idle"}, {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      check({tag, ".pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int doneCnt;
      reset = 1'b1; start = 1'b0; op = 2'b00; flush = 1'b0;
      operandA = '0; operandB = '0; wrHi = 1'b0; wrLo = 1'b0; wrData = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst.busy", {63'd0, busy}, 64'd0);
      check("rst.done", {63'd0, done}, 64'd0);
      check("rst.dz", {63'd0, divZero}, 64'd0);
      check("rst.hilo", {hi, lo}, 64'd0);

      runOp("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      runOp("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
      runOp("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      runOp("divu_100d7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
      runOp("div_by0", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1);
      runOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

      // mthi preload, then flush mid-multiply
      wrHi = 1'b1; wrData = 32'hAAAA0000;
      @(posedge clk); #1;
      wrHi = 1'b0;
      check("mthi.hi", {32'd0, hi}, {32'd0, 32'hAAAA0000});
      start = 1'b1; op = 2'b01; operandA = 32'hFFFFFFFF; operandB = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush.busy", {63'd0, busy}, 64'd0);
      check("flush.done", {63'd0, done}, 64'd0);
      check("flush.hi", {32'd0, hi}, {32'd0, 32'hAAAA0000});
      doneCnt = 0;
      repeat (40) begin @(posedge clk); #1; if (done === 1'b1) doneCnt++; end
      check("flush.nodone", 64'(doneCnt), 64'd0);

      // start while busy is ignored
      start = 1'b1; op = 2'b01; operandA = 32'd3; operandB = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; operandA = 32'd2; operandB = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      doneCnt = 0;
      repeat (60) begin @(posedge clk); #1; if (done === 1'b1) doneCnt++; end
      check("busystart.dones", 64'(doneCnt), 64'd1);
      check("busystart.lo", {32'd0, lo}, 64'h0F);

      // mtlo ignored while busy, then reset mid-operation
      runOp("div_1d0", 2'b10, 32'd1, 32'd0, 32'h00000001, 32'hFFFFFFFF, 1'b1);
      start = 1'b1; op = 2'b01; operandA = 32'hFFFFFFFF; operandB = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      wrLo = 1'b1; wrData = 32'h55;
      @(posedge clk); #1;
      wrLo = 1'b0;
      check("mtlo_busy.lo", {32'd0, lo}, {32'd0, 32'hFFFFFFFF});
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst.busy", {63'd0, busy}, 64'd0);
      check("midrst.hilo", {hi, lo}, 64'd0);
      check("midrst.dz", {63'd0, divZero}, 64'd0);
      wrLo = 1'b1; wrData = 32'h55;
      @(posedge clk); #1;
      wrLo = 1'b0;
      check("mtlo_idle.lo", {32'd0, lo}, 64'h55);

      runOp("mult_9x3", 2'b00, 32'd9, 32'd3, 32'h00000000, 32'h0000001B, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
